// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - request/result handshake between mdu_ctrl and the mul/div unit
interface mdu_ctrl_if;
    logic        u_valid;
    logic        u_ready;
    logic [1:0]  u_op;
    logic        u_sign;
    logic [31:0] u_src0;
    logic [31:0] u_src1;
    logic        u_res_valid;
    logic        u_res_ready;
    logic [31:0] u_res0;
    logic [31:0] u_res1;

    modport master (
        output u_valid, u_op, u_sign, u_src0, u_src1, u_res_ready,
        input  u_ready, u_res_valid, u_res0, u_res1
    );

    modport slave (
        input  u_valid, u_op, u_sign, u_src0, u_src1, u_res_ready,
        output u_ready, u_res_valid, u_res0, u_res1
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage HI/LO controller sequencing a multi-cycle mul/div unit
module mdu_ctrl #(
    parameter int DIV0_KEEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [3:0]        op,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    output logic              stall,
    output logic [31:0]       rd_data,
    output logic [31:0]       hi_q,
    output logic [31:0]       lo_q,
    mdu_ctrl_if.master        unit
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        issue;
    logic        is_muldiv;
    logic        div0_skip;
    logic [1:0]  uop_q;
    logic        sign_q;
    logic [31:0] src0_q, src1_q;

    assign unit.u_op   = uop_q;
    assign unit.u_sign = sign_q;
    assign unit.u_src0 = src0_q;
    assign unit.u_src1 = src1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue is decided from state_q only, so u_ready never reaches stall.
    always_comb begin
        state_d          = state_q;
        issue            = 1'b0;
        is_muldiv        = (op >= OP_MULT) && (op <= OP_DIVU);
        div0_skip        = (DIV0_KEEP != 0) && ((op == OP_DIV) || (op == OP_DIVU))
                           && (rt_data == 32'd0);
        stall            = (op >= OP_MULT) && (op <= OP_MTLO) && (state_q != IDLE);
        unit.u_valid     = (state_q == ISSUE);
        unit.u_res_ready = (state_q == WAIT);
        case (op)
            OP_MFHI: rd_data = hi_q;
            OP_MFLO: rd_data = lo_q;
            default: rd_data = 32'd0;
        endcase
        case (state_q)
            IDLE: begin
                if (!req && is_muldiv && !div0_skip) begin
                    state_d = ISSUE;
                    issue   = 1'b1;
                end
            end
            ISSUE: if (unit.u_ready) state_d = WAIT;
            WAIT:  if (unit.u_res_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            uop_q  <= 2'b00;
            sign_q <= 1'b0;
            src0_q <= 32'd0;
            src1_q <= 32'd0;
        end else if (issue) begin
            src0_q <= rs_data;
            src1_q <= rt_data;
            uop_q  <= (op <= OP_MULTU) ? 2'b01 : 2'b10;
            sign_q <= (op == OP_MULT) || (op == OP_DIV);
        end else if (state_q == WAIT && unit.u_res_valid) begin
            hi_q  <= unit.u_res1;
            lo_q  <= unit.u_res0;
            uop_q <= 2'b00;
        end else if (state_q == IDLE && !req) begin
            if (op == OP_MTHI) hi_q <= rs_data;
            if (op == OP_MTLO) lo_q <= rs_data;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed, table and randomized checks of mdu_ctrl against an instruction-level model
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        stall;
    logic [31:0] rd_data, hi_q, lo_q;

    mdu_ctrl_if bus();

    mdu_ctrl #(.DIV0_KEEP(1)) dut (
        .clk(clk), .reset(rst), .req(req), .op(op), .rs_data(rs), .rt_data(rt),
        .stall(stall), .rd_data(rd_data), .hi_q(hi_q), .lo_q(lo_q), .unit(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          cfg_delay = 0;
    int          cfg_lat   = 1;
    logic        unit_auto = 1'b1;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_res   = 32'd0;
    int          ph  = 0;
    int          cnt = 0;
    logic [63:0] ures;

    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic        m_busy, m_acc, m_sgn;
    logic [1:0]  m_uop;
    logic [63:0] m_res;

    logic        last_stall, last_uvalid, last_rrdy;
    logic [31:0] last_rd;

    typedef struct {
        logic [3:0]  op;
        logic        req;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stall;
        logic [31:0] rd;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        uv;
    } vec_t;
    vec_t tbl[13];

    // Architectural result of a mul/div: {HI, LO}; divide gives remainder in HI.
    function automatic logic [63:0] mdu_compute(input logic [1:0] uop, input logic sgn,
                                                input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        if (uop == 2'b01) return sa * sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unit_accept();
        bus.u_ready = 1'b1;
        ures = mdu_compute(bus.u_op, bus.u_sign, bus.u_src0, bus.u_src1);
        cnt  = cfg_lat - 1;
        ph   = 2;
    endtask

    initial begin
        bus.u_ready = 1'b0; bus.u_res_valid = 1'b0; bus.u_res0 = 32'd0; bus.u_res1 = 32'd0;
        forever begin
            @(posedge clk); #1;
            bus.u_ready     = 1'b0;
            bus.u_res_valid = 1'b0;
            if (rst || !unit_auto) begin
                ph = 0;
                bus.u_res_valid = inj_valid;
                bus.u_res0 = inj_res;
                bus.u_res1 = inj_res;
            end else begin
                case (ph)
                    0: if (bus.u_valid) begin
                        if (cfg_delay == 0) unit_accept();
                        else begin cnt = cfg_delay; ph = 1; end
                    end
                    1: begin cnt--; if (cnt == 0) unit_accept(); end
                    2: if (cnt == 0) begin
                        bus.u_res_valid = 1'b1;
                        bus.u_res0 = ures[31:0];
                        bus.u_res1 = ures[63:32];
                        ph = 3;
                    end else cnt--;
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_a = 32'd0; m_b = 32'd0;
        m_busy = 1'b0; m_acc = 1'b0; m_sgn = 1'b0; m_uop = 2'b00; m_res = 64'd0;
    endtask

    task automatic model_check();
        logic        exp_stall;
        logic [31:0] exp_rd;
        exp_stall = (op >= 4'd1) && (op <= 4'd8) && m_busy;
        exp_rd    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        chk("m_stall", 32'(stall), 32'(exp_stall));
        if (!exp_stall) chk("m_rd", rd_data, exp_rd);
        chk("m_hi", hi_q, m_hi);
        chk("m_lo", lo_q, m_lo);
        chk("m_u_valid", 32'(bus.u_valid), 32'(m_busy && !m_acc));
        chk("m_u_res_ready", 32'(bus.u_res_ready), 32'(m_busy && m_acc));
        if (m_busy && !m_acc) begin
            chk("m_src0", bus.u_src0, m_a);
            chk("m_src1", bus.u_src1, m_b);
            chk("m_u_op", 32'(bus.u_op), 32'(m_uop));
            chk("m_u_sign", 32'(bus.u_sign), 32'(m_sgn));
        end
    endtask

    task automatic model_step();
        if (m_busy && m_acc) begin
            if (bus.u_res_valid) begin
                m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_busy = 1'b0; m_acc = 1'b0;
            end
        end else if (m_busy) begin
            if (bus.u_ready) m_acc = 1'b1;
        end else if (!req) begin
            if (op >= 4'd1 && op <= 4'd4 && !(op >= 4'd3 && rt == 32'd0)) begin
                m_busy = 1'b1; m_acc = 1'b0; m_a = rs; m_b = rt;
                m_uop  = (op <= 4'd2) ? 2'b01 : 2'b10;
                m_sgn  = (op == 4'd1) || (op == 4'd3);
                m_res  = mdu_compute(m_uop, m_sgn, rs, rt);
            end else if (op == 4'd7) m_hi = rs;
            else if (op == 4'd8) m_lo = rs;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        last_stall = stall; last_rd = rd_data; last_uvalid = bus.u_valid; last_rrdy = bus.u_res_ready;
        model_check();
        model_step();
    endtask

    task automatic advance();
        @(posedge clk); #2;
    endtask

    task automatic cycle(input logic [3:0] o, input logic r, input logic [31:0] a, input logic [31:0] b);
        op = o; req = r; rs = a; rt = b;
        settle();
        advance();
    endtask

    task automatic run_until_free(input logic [3:0] o, input logic r, input logic [31:0] a,
                                  output int nval, output logic done, output logic first_stall);
        nval = 0; done = 1'b0; first_stall = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            op = o; req = r; rs = a; rt = 32'd0;
            settle();
            if (k == 0) first_stall = last_stall;
            nval += int'(last_uvalid);
            if (!last_stall) done = 1'b1;
            advance();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   nval;
        logic done, fst;

        tbl[0]  = '{4'd7,  1'b0, 32'h1111_2222, 32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'd0,         1'b0};
        tbl[1]  = '{4'd8,  1'b0, 32'hA5A5_A5A5, 32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[2]  = '{4'd6,  1'b0, 32'd0,         32'd0, 1'b0, 32'hA5A5_A5A5, 32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[3]  = '{4'd5,  1'b0, 32'd0,         32'd0, 1'b0, 32'h1111_2222, 32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[4]  = '{4'd7,  1'b1, 32'h0000_1234, 32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[5]  = '{4'd1,  1'b1, 32'd3,         32'd4, 1'b0, 32'd0,         32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[6]  = '{4'd4,  1'b0, 32'd9,         32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[7]  = '{4'd3,  1'b0, 32'h8000_0000, 32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[8]  = '{4'd12, 1'b0, 32'h7777_7777, 32'd1, 1'b0, 32'd0,         32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[9]  = '{4'd8,  1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[10] = '{4'd6,  1'b1, 32'd0,         32'd0, 1'b0, 32'hA5A5_A5A5, 32'h1111_2222, 32'hA5A5_A5A5, 1'b0};
        tbl[11] = '{4'd8,  1'b0, 32'd0,         32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'd0,         1'b0};
        tbl[12] = '{4'd6,  1'b0, 32'd0,         32'd0, 1'b0, 32'd0,         32'h1111_2222, 32'd0,         1'b0};

        rst = 1'b1; req = 1'b0; op = 4'd1; rs = 32'd5; rt = 32'd6;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_u_valid", 32'(bus.u_valid), 32'd0);
        chk("rst_u_res_ready", 32'(bus.u_res_ready), 32'd0);
        chk("rst_u_op", 32'(bus.u_op), 32'd0);
        chk("rst_u_sign", 32'(bus.u_sign), 32'd0);
        chk("rst_src0", bus.u_src0, 32'd0);
        chk("rst_src1", bus.u_src1, 32'd0);
        chk("rst_hi", hi_q, 32'd0);
        chk("rst_lo", lo_q, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0; op = 4'd0;

        foreach (tbl[i]) begin
            op = tbl[i].op; req = tbl[i].req; rs = tbl[i].rs; rt = tbl[i].rt;
            settle();
            chk($sformatf("tbl%0d_stall", i), 32'(last_stall), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d_rd", i), last_rd, tbl[i].rd);
            advance();
            chk($sformatf("tbl%0d_hi", i), hi_q, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), lo_q, tbl[i].lo);
            chk($sformatf("tbl%0d_uvalid", i), 32'(bus.u_valid), 32'(tbl[i].uv));
        end

        // mult -1*2 with latency 5; mflo (flushed, req=1) must wait and then read LO
        cfg_delay = 0; cfg_lat = 5;
        op = 4'd1; req = 1'b0; rs = 32'hFFFF_FFFF; rt = 32'd2;
        settle();
        chk("mult_issue_stall", 32'(last_stall), 32'd0);
        advance();
        run_until_free(4'd6, 1'b1, 32'd0, nval, done, fst);
        chk("mult_done", 32'(done), 32'd1);
        chk("mflo_stalls", 32'(fst), 32'd1);
        chk("mult_valid_cycles", 32'(nval), 32'd1);
        chk("mflo_after_mult", last_rd, 32'hFFFF_FFFE);
        chk("mult_hi", hi_q, 32'hFFFF_FFFF);

        cycle(4'd4, 1'b0, 32'd7, 32'd2);
        run_until_free(4'd5, 1'b0, 32'd0, nval, done, fst);
        chk("divu_done", 32'(done), 32'd1);
        chk("divu_hi_rd", last_rd, 32'd1);
        chk("divu_lo", lo_q, 32'd3);

        // ready held low 3 cycles; mthi waits behind the multu
        cfg_delay = 3; cfg_lat = 2;
        cycle(4'd2, 1'b0, 32'h8000_0000, 32'd3);
        run_until_free(4'd7, 1'b0, 32'h0000_BEEF, nval, done, fst);
        chk("slow_done", 32'(done), 32'd1);
        chk("slow_mthi_stalls", 32'(fst), 32'd1);
        chk("slow_valid_cycles", 32'(nval), 32'd4);
        chk("slow_lo", lo_q, 32'h8000_0000);
        chk("slow_hi_after_mthi", hi_q, 32'h0000_BEEF);

        // reset while waiting for a result, then a stale result arrives
        cfg_delay = 0; cfg_lat = 30;
        cycle(4'd3, 1'b0, 32'd100, 32'd7);
        for (int k = 0; k < 10; k++) begin
            cycle(4'd5, 1'b0, 32'd0, 32'd0);
            if (last_rrdy) break;
        end
        chk("wait_reached", 32'(last_rrdy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_u_res_ready", 32'(bus.u_res_ready), 32'd0);
        chk("mid_rst_hi", hi_q, 32'd0);
        chk("mid_rst_lo", lo_q, 32'd0);
        model_reset();
        @(posedge clk); #2;
        rst = 1'b0; unit_auto = 1'b0; inj_valid = 1'b1; inj_res = 32'h0000_DEAD;
        repeat (3) cycle(4'd5, 1'b0, 32'd0, 32'd0);
        chk("stale_res_stall", 32'(last_stall), 32'd0);
        chk("stale_res_hi", hi_q, 32'd0);
        chk("stale_res_lo", lo_q, 32'd0);
        cycle(4'd7, 1'b0, 32'h0000_0055, 32'd0);
        cycle(4'd0, 1'b0, 32'd0, 32'd0);
        chk("idle_res_hi", hi_q, 32'h0000_0055);
        chk("idle_res_lo", lo_q, 32'd0);
        inj_valid = 1'b0; unit_auto = 1'b1;
        cycle(4'd0, 1'b0, 32'd0, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  o;
            logic        r;
            logic [31:0] a, b;
            cfg_delay = int'($urandom_range(0, 3));
            cfg_lat   = int'($urandom_range(1, 6));
            o = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(1, 4));
            r = ($urandom_range(0, 7) == 0);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            cycle(o, r, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter: DIV0_KEEP, default 1, meaning: 1 = div/divu with rt_data==0 is not issued and HI/LO stay unchanged; 0 = issued like any other divide.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  async active-high reset.
REQ-005 req  in  1  exception/interrupt flush of the E-stage instruction; when high, the current op has no effect.
REQ-006 op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-007 rs_data  in  32  first operand; also the mthi/mtlo source.
REQ-008 rt_data  in  32  second operand.
REQ-009 stall  out  1  E-stage hold request.
REQ-010 rd_data  out  32  mfhi/mflo result; 0 for all other ops.
REQ-011 u_valid  out  1  request valid to the mul/div unit.
REQ-012 u_ready  in  1  unit accepts the request.
REQ-013 u_op  out  2  01 = multiply, 10 = divide, 00 = idle.
REQ-014 u_sign  out  1  1 = signed (mult/div).
REQ-015 u_src0, u_src1  out  32 each  latched rs/rt operands.
REQ-016 u_res_valid  in  1  unit result valid.
REQ-017 u_res_ready  out  1  controller accepts the result.
REQ-018 u_res0, u_res1  in  32 each  LO and HI results.
REQ-019 hi_q, lo_q  out  32 each  architectural HI and LO.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-021 IDLE -> ISSUE on an edge where op is 1-4, req=0, and the op is not a skipped div0; at that edge the block SHALL latch rs/rt into u_src0/u_src1 and latch u_op/u_sign.
REQ-022 The issuing mul/div op SHALL NOT itself stall (stall=0 in IDLE).
REQ-023 In ISSUE, u_valid=1 with stable u_src*/u_op/u_sign; ISSUE -> WAIT on the edge where u_ready=1; u_valid=0 in every other state.
REQ-024 In WAIT, u_res_ready=1; on the edge with u_res_valid=1, HI<=u_res1 and LO<=u_res0, and WAIT -> IDLE.
REQ-025 stall = (op in 1-8) AND (state != IDLE), independent of req.
REQ-026 mthi/mtlo in IDLE with req=0 SHALL write rs_data to HI/LO at that edge.
REQ-027 rd_data = HI for op 5 and LO for op 6, using the current register value; rd_data is meaningful only when stall=0.
REQ-028 req=1 in IDLE SHALL suppress issue and mthi/mtlo writes.
REQ-029 req=1 in ISSUE/WAIT SHALL NOT cancel the in-flight operation, which already committed.
REQ-030 With DIV0_KEEP=1, op 3/4 with rt_data==0 SHALL leave the FSM in IDLE with HI/LO unchanged.
REQ-031 An unexpected u_res_valid in IDLE or ISSUE SHALL be ignored.
REQ-032 The IDLE->ISSUE decision SHALL depend only on registered state, with no combinational path from u_ready to stall.

Reset
REQ-033 Asynchronous reset SHALL force state=IDLE, HI=LO=0, u_valid=0, u_res_ready=0, u_op=00, u_sign=0, u_src0=u_src1=0, and stall=0 combinationally.
REQ-034 Reset mid-operation SHALL abandon the operation; a result arriving after reset is released SHALL be discarded per REQ-031.

Verification
REQ-035 Scenario: op=1 (mult), rs=0xFFFFFFFF, rt=2, unit latency 5 -> u_valid high for 1 cycle; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE; a following mflo stalls until WAIT->IDLE, then rd_data=0xFFFFFFFE.
REQ-036 Scenario: op=4 (divu), rs=7, rt=2 -> LO=3, HI=1; with DIV0_KEEP=1, a divu with rt=0 -> no u_valid, HI/LO unchanged, stall=0.
REQ-037 Scenario: u_ready held low for 3 cycles in ISSUE -> u_valid and u_src* stay stable for those 3 cycles; mthi during the wait stalls and has no effect.
REQ-038 Scenario: op=1 with req=1 -> no issue, HI/LO unchanged; mthi rs=0x1234 with req=1 -> HI unchanged.
REQ-039 Scenario: reset asserted in WAIT, then u_res_valid=1 with res=0xDEAD -> HI=LO=0, state IDLE, result ignored.
REQ-040 Scenario: mtlo 0xA5A5A5A5 then mflo on the next cycle -> rd_data=0xA5A5A5A5 with no stall.
